// File: rtl/vr_tx_merge_eng.sv
// Round-robin merge of four VR engine TX streams into one UDP TX stream, prepending beehive_hdr.
// Optional per-source completed-message counters: define VR_TX_MERGE_STATS_EN.
package vr_tx_merge_pkg;
  localparam int BEEHIVE_HDR_W     = 96;
  localparam int BEEHIVE_HDR_BYTES = BEEHIVE_HDR_W / 8;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_info;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [23:0] src_id;
    logic [31:0] view;
    logic [31:0] op_num;
  } beehive_hdr;

  typedef enum logic [2:0] {
    ST_IDLE, ST_META_OUT, ST_FIRST, ST_DATA, ST_DRAIN
  } merge_state_e;
endpackage

// Handshake: a beat/meta transfers on a rising clk edge where val && rdy; a producer holds
// val and payload stable until that edge, and rdy never waits on anything but val.
module vr_tx_merge_eng
  import vr_tx_merge_pkg::*;
#(
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
  parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      prep_tx_meta_val,
  input  udp_info                   prep_tx_meta_info,
  input  beehive_hdr                prep_tx_hdr,
  output logic                      tx_prep_meta_rdy,
  input  logic                      prep_tx_data_val,
  input  logic [NOC_DATA_W-1:0]     prep_tx_data,
  input  logic                      prep_tx_data_last,
  input  logic [NOC_PADBYTES_W-1:0] prep_tx_data_padbytes,
  output logic                      tx_prep_data_rdy,
  input  logic                      commit_tx_meta_val,
  input  udp_info                   commit_tx_meta_info,
  input  beehive_hdr                commit_tx_hdr,
  output logic                      tx_commit_meta_rdy,
  input  logic                      commit_tx_data_val,
  input  logic [NOC_DATA_W-1:0]     commit_tx_data,
  input  logic                      commit_tx_data_last,
  input  logic [NOC_PADBYTES_W-1:0] commit_tx_data_padbytes,
  output logic                      tx_commit_data_rdy,
  input  logic                      vc_tx_meta_val,
  input  udp_info                   vc_tx_meta_info,
  input  beehive_hdr                vc_tx_hdr,
  output logic                      tx_vc_meta_rdy,
  input  logic                      vc_tx_data_val,
  input  logic [NOC_DATA_W-1:0]     vc_tx_data,
  input  logic                      vc_tx_data_last,
  input  logic [NOC_PADBYTES_W-1:0] vc_tx_data_padbytes,
  output logic                      tx_vc_data_rdy,
  input  logic                      setup_tx_meta_val,
  input  udp_info                   setup_tx_meta_info,
  input  beehive_hdr                setup_tx_hdr,
  output logic                      tx_setup_meta_rdy,
  input  logic                      setup_tx_data_val,
  input  logic [NOC_DATA_W-1:0]     setup_tx_data,
  input  logic                      setup_tx_data_last,
  input  logic [NOC_PADBYTES_W-1:0] setup_tx_data_padbytes,
  output logic                      tx_setup_data_rdy,
  output logic                      merge_udp_meta_val,
  output udp_info                   merge_udp_meta_info,
  input  logic                      udp_merge_meta_rdy,
  output logic                      merge_udp_data_val,
  output logic [NOC_DATA_W-1:0]     merge_udp_data,
  output logic                      merge_udp_data_last,
  output logic [NOC_PADBYTES_W-1:0] merge_udp_data_padbytes,
  input  logic                      udp_merge_data_rdy,
  output merge_state_e              state_dbg
`ifdef VR_TX_MERGE_STATS_EN
  ,
  output logic [3:0][31:0]          tx_msg_cnt
`endif
);
  localparam int HW = BEEHIVE_HDR_W;
  localparam int H  = BEEHIVE_HDR_BYTES;
  localparam int LW = NOC_DATA_W - HW;

  logic [3:0]                meta_val_a, data_val_a, last_a, meta_rdy_a, data_rdy_a;
  udp_info                   info_a [4];
  beehive_hdr                hdr_a  [4];
  logic [NOC_DATA_W-1:0]     data_a [4];
  logic [NOC_PADBYTES_W-1:0] pad_a  [4];

  assign meta_val_a = {setup_tx_meta_val, vc_tx_meta_val, commit_tx_meta_val, prep_tx_meta_val};
  assign data_val_a = {setup_tx_data_val, vc_tx_data_val, commit_tx_data_val, prep_tx_data_val};
  assign last_a     = {setup_tx_data_last, vc_tx_data_last, commit_tx_data_last, prep_tx_data_last};
  assign info_a = '{prep_tx_meta_info, commit_tx_meta_info, vc_tx_meta_info, setup_tx_meta_info};
  assign hdr_a  = '{prep_tx_hdr, commit_tx_hdr, vc_tx_hdr, setup_tx_hdr};
  assign data_a = '{prep_tx_data, commit_tx_data, vc_tx_data, setup_tx_data};
  assign pad_a  = '{prep_tx_data_padbytes, commit_tx_data_padbytes, vc_tx_data_padbytes,
                    setup_tx_data_padbytes};

  assign {tx_setup_meta_rdy, tx_vc_meta_rdy, tx_commit_meta_rdy, tx_prep_meta_rdy} = meta_rdy_a;
  assign {tx_setup_data_rdy, tx_vc_data_rdy, tx_commit_data_rdy, tx_prep_data_rdy} = data_rdy_a;

  merge_state_e              state_q, state_d;
  logic [1:0]                rr_ptr_q, grant_q, grant_idx;
  logic                      grant_val, xfer, done;
  udp_info                   info_q;
  beehive_hdr                hdr_q;
  logic [HW-1:0]             carry_q;
  logic [NOC_PADBYTES_W-1:0] pad_q;

  logic                      sel_val, sel_last;
  logic [NOC_DATA_W-1:0]     sel_data;
  logic [NOC_PADBYTES_W-1:0] sel_pad;

  assign sel_val   = data_val_a[grant_q];
  assign sel_last  = last_a[grant_q];
  assign sel_data  = data_a[grant_q];
  assign sel_pad   = pad_a[grant_q];
  assign state_dbg = state_q;

  // Scan from the highest offset down so the source nearest rr_ptr wins.
  always_comb begin
    grant_val = 1'b0;
    grant_idx = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (meta_val_a[rr_ptr_q + 2'(i)]) begin
        grant_val = 1'b1;
        grant_idx = rr_ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d                 = state_q;
    meta_rdy_a              = '0;
    data_rdy_a              = '0;
    merge_udp_meta_val      = 1'b0;
    merge_udp_meta_info     = '0;
    merge_udp_data_val      = 1'b0;
    merge_udp_data          = '0;
    merge_udp_data_last     = 1'b0;
    merge_udp_data_padbytes = '0;
    xfer                    = 1'b0;
    done                    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_val && rst_n) begin
          meta_rdy_a[grant_idx] = 1'b1;
          state_d               = ST_META_OUT;
        end
      end
      ST_META_OUT: begin
        merge_udp_meta_val              = 1'b1;
        merge_udp_meta_info             = info_q;
        merge_udp_meta_info.data_length = info_q.data_length + 16'(H);
        if (udp_merge_meta_rdy) state_d = ST_FIRST;
      end
      ST_FIRST, ST_DATA: begin
        merge_udp_data_val  = sel_val;
        data_rdy_a[grant_q] = udp_merge_data_rdy;
        merge_udp_data      = {(state_q == ST_FIRST) ? HW'(hdr_q) : carry_q,
                               sel_data[NOC_DATA_W-1:HW]};
        // The tail fits in this beat only if the input left at least a header's worth of room.
        if (sel_last && (sel_pad >= NOC_PADBYTES_W'(H))) begin
          merge_udp_data_last     = 1'b1;
          merge_udp_data_padbytes = sel_pad - NOC_PADBYTES_W'(H);
        end
        xfer = sel_val && udp_merge_data_rdy;
        if (xfer) begin
          if (!sel_last) state_d = ST_DATA;
          else if (sel_pad >= NOC_PADBYTES_W'(H)) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end else state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        merge_udp_data_val      = 1'b1;
        merge_udp_data          = {carry_q, {LW{1'b0}}};
        merge_udp_data_last     = 1'b1;
        merge_udp_data_padbytes = NOC_PADBYTES_W'(NOC_PADBYTES - H) + pad_q;
        if (udp_merge_data_rdy) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 2'd0;
      grant_q  <= 2'd0;
      info_q   <= '0;
      hdr_q    <= '0;
      carry_q  <= '0;
      pad_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && grant_val) begin
        grant_q <= grant_idx;
        info_q  <= info_a[grant_idx];
        hdr_q   <= hdr_a[grant_idx];
      end
      if (xfer) begin
        carry_q <= sel_data[HW-1:0];
        if (sel_last) pad_q <= sel_pad;
      end
      if (done) rr_ptr_q <= grant_q + 2'd1;
    end
  end

`ifdef VR_TX_MERGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_msg_cnt <= '0;
    else if (done) tx_msg_cnt[grant_q] <= tx_msg_cnt[grant_q] + 32'd1;
  end
`endif
endmodule

// File: tb/tb_vr_tx_merge_eng.sv
// Bench for vr_tx_merge_eng: directed messages, byte-stream reference model, queue scoreboard.
module tb_vr_tx_merge_eng;
  import vr_tx_merge_pkg::*;

  localparam int NW     = 512;
  localparam int PB     = NW / 8;
  localparam int PW     = $clog2(PB);
  localparam int HW     = BEEHIVE_HDR_W;
  localparam int H      = BEEHIVE_HDR_BYTES;
  localparam int EW     = NW + 1 + PW;
  localparam int BUDGET = 300;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            s_meta_val [4];
  udp_info         s_info     [4];
  beehive_hdr      s_hdr      [4];
  logic            s_meta_rdy [4];
  logic            s_data_val [4];
  logic [NW-1:0]   s_data     [4];
  logic            s_last     [4];
  logic [PW-1:0]   s_pad      [4];
  logic            s_data_rdy [4];

  logic            merge_udp_meta_val;
  udp_info         merge_udp_meta_info;
  logic            udp_merge_meta_rdy;
  logic            merge_udp_data_val;
  logic [NW-1:0]   merge_udp_data;
  logic            merge_udp_data_last;
  logic [PW-1:0]   merge_udp_data_padbytes;
  logic            udp_merge_data_rdy;
  merge_state_e    state_dbg;
`ifdef VR_TX_MERGE_STATS_EN
  logic [3:0][31:0] tx_msg_cnt;
`endif

  vr_tx_merge_eng #(.NOC_DATA_W(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .prep_tx_meta_val(s_meta_val[0]), .prep_tx_meta_info(s_info[0]), .prep_tx_hdr(s_hdr[0]),
    .tx_prep_meta_rdy(s_meta_rdy[0]), .prep_tx_data_val(s_data_val[0]), .prep_tx_data(s_data[0]),
    .prep_tx_data_last(s_last[0]), .prep_tx_data_padbytes(s_pad[0]), .tx_prep_data_rdy(s_data_rdy[0]),
    .commit_tx_meta_val(s_meta_val[1]), .commit_tx_meta_info(s_info[1]), .commit_tx_hdr(s_hdr[1]),
    .tx_commit_meta_rdy(s_meta_rdy[1]), .commit_tx_data_val(s_data_val[1]),
    .commit_tx_data(s_data[1]), .commit_tx_data_last(s_last[1]),
    .commit_tx_data_padbytes(s_pad[1]), .tx_commit_data_rdy(s_data_rdy[1]),
    .vc_tx_meta_val(s_meta_val[2]), .vc_tx_meta_info(s_info[2]), .vc_tx_hdr(s_hdr[2]),
    .tx_vc_meta_rdy(s_meta_rdy[2]), .vc_tx_data_val(s_data_val[2]), .vc_tx_data(s_data[2]),
    .vc_tx_data_last(s_last[2]), .vc_tx_data_padbytes(s_pad[2]), .tx_vc_data_rdy(s_data_rdy[2]),
    .setup_tx_meta_val(s_meta_val[3]), .setup_tx_meta_info(s_info[3]), .setup_tx_hdr(s_hdr[3]),
    .tx_setup_meta_rdy(s_meta_rdy[3]), .setup_tx_data_val(s_data_val[3]),
    .setup_tx_data(s_data[3]), .setup_tx_data_last(s_last[3]),
    .setup_tx_data_padbytes(s_pad[3]), .tx_setup_data_rdy(s_data_rdy[3]),
    .merge_udp_meta_val(merge_udp_meta_val), .merge_udp_meta_info(merge_udp_meta_info),
    .udp_merge_meta_rdy(udp_merge_meta_rdy), .merge_udp_data_val(merge_udp_data_val),
    .merge_udp_data(merge_udp_data), .merge_udp_data_last(merge_udp_data_last),
    .merge_udp_data_padbytes(merge_udp_data_padbytes), .udp_merge_data_rdy(udp_merge_data_rdy),
    .state_dbg(state_dbg)
`ifdef VR_TX_MERGE_STATS_EN
    , .tx_msg_cnt(tx_msg_cnt)
`endif
  );

  // message store and scoreboard
  logic [7:0]  pay [4][512];
  udp_info     info_src [4];
  beehive_hdr  hdr_src  [4];
  int          exp_cnt  [4];
  logic [EW-1:0] exp_q[$];
  udp_info       exp_meta_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int beats_seen = 0;
  int meta_stall_cfg = 0;
  bit data_toggle = 1'b0;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void set_msg(input int s, input int len);
    info_src[s].src_ip      = $urandom;
    info_src[s].dst_ip      = $urandom;
    info_src[s].src_port    = 16'($urandom_range(0, 65535));
    info_src[s].dst_port    = 16'(s);
    info_src[s].data_length = 16'(len);
    hdr_src[s] = {$urandom, $urandom, $urandom};
    for (int i = 0; i < len; i++) pay[s][i] = 8'($urandom_range(0, 255));
  endfunction

  // Reference: output byte stream is hdr ++ payload, cut into zero-padded beats.
  function automatic void push_exp(input int s, input int len);
    logic [7:0]    st[$];
    logic [HW-1:0] hv;
    logic [NW-1:0] beat;
    udp_info       m;
    int            total, nb;
    hv = hdr_src[s];
    for (int i = 0; i < H; i++) st.push_back(hv[HW-1-8*i -: 8]);
    for (int i = 0; i < len; i++) st.push_back(pay[s][i]);
    total = H + len;
    nb = (total + PB - 1) / PB;
    for (int b = 0; b < nb; b++) begin
      beat = '0;
      for (int j = 0; j < PB; j++)
        if (b * PB + j < total) beat[NW-1-8*j -: 8] = st[b * PB + j];
      exp_q.push_back({beat, (b == nb - 1), (b == nb - 1) ? PW'(nb * PB - total) : PW'(0)});
    end
    m = info_src[s];
    m.data_length = m.data_length + 16'(H);
    exp_meta_q.push_back(m);
    exp_cnt[s]++;
  endfunction

  // driver: one message on source s; gives up quietly if reset is asserted
  task automatic drive_src(input int s, input int len);
    int nb, n;
    logic [NW-1:0] beat;
    nb = (len + PB - 1) / PB;
    s_info[s] = info_src[s];
    s_hdr[s] = hdr_src[s];
    s_meta_val[s] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (rst_n && !s_meta_rdy[s] && n < BUDGET);
    if (!rst_n) begin s_meta_val[s] = 1'b0; return; end
    chk("meta_grant", s_meta_rdy[s], 1'b1);
    @(posedge clk); #1;
    s_meta_val[s] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      beat = '0;
      for (int j = 0; j < PB; j++)
        if (b * PB + j < len) beat[NW-1-8*j -: 8] = pay[s][b * PB + j];
      s_data[s] = beat;
      s_last[s] = (b == nb - 1);
      s_pad[s] = (b == nb - 1) ? PW'(nb * PB - len) : PW'(0);
      s_data_val[s] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (rst_n && !s_data_rdy[s] && n < BUDGET);
      if (!rst_n || !s_data_rdy[s]) begin
        if (rst_n) chk("data_accept", s_data_rdy[s], 1'b1);
        b = nb;
      end else begin
        @(posedge clk); #1;
      end
    end
    s_data_val[s] = 1'b0;
    s_last[s] = 1'b0;
    s_data[s] = '0;
    s_pad[s] = '0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_meta_q.size() != 0) && n < BUDGET) begin
      @(negedge clk); n++;
    end
    chk("drain_beats_left", exp_q.size(), 0);
    chk("drain_meta_left", exp_meta_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
  endtask

  // sink: meta stall window and optional toggling data ready
  initial begin
    int stalls = 0;
    udp_merge_meta_rdy = 1'b0;
    udp_merge_data_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (merge_udp_meta_val && stalls < meta_stall_cfg) begin
        udp_merge_meta_rdy = 1'b0;
        stalls++;
      end else udp_merge_meta_rdy = 1'b1;
      udp_merge_data_rdy = data_toggle ? ~udp_merge_data_rdy : 1'b1;
    end
  end

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] cur, prev_beat, eb;
    udp_info prev_meta, em;
    bit pb = 1'b0, pm = 1'b0;
    forever begin
      @(negedge clk);
      cur = {merge_udp_data, merge_udp_data_last, merge_udp_data_padbytes};
      if (!rst_n) begin
        pb = 1'b0;
        pm = 1'b0;
      end else begin
        if (pm) begin
          chk("meta_hold_val", merge_udp_meta_val, 1'b1);
          chk("meta_hold_info", merge_udp_meta_info, prev_meta);
        end
        if (pb) begin
          chk("data_hold_val", merge_udp_data_val, 1'b1);
          chk("data_hold_beat", cur, prev_beat);
        end
        if (state_dbg == ST_DRAIN)
          chk("drain_src_rdy", {s_data_rdy[0], s_data_rdy[1], s_data_rdy[2], s_data_rdy[3]}, 4'b0);
        if (merge_udp_meta_val && udp_merge_meta_rdy) begin
          if (exp_meta_q.size() == 0) chk("meta_unexpected", exp_meta_q.size(), 1);
          else begin
            em = exp_meta_q.pop_front();
            chk("meta_info", merge_udp_meta_info, em);
          end
        end
        if (merge_udp_data_val && udp_merge_data_rdy) begin
          beats_seen++;
          if (exp_q.size() == 0) chk("beat_unexpected", exp_q.size(), 1);
          else begin
            eb = exp_q.pop_front();
            chk("out_beat", cur, eb);
          end
        end
        pm = merge_udp_meta_val && !udp_merge_meta_rdy;
        pb = merge_udp_data_val && !udp_merge_data_rdy;
        prev_meta = merge_udp_meta_info;
        prev_beat = cur;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    for (int i = 0; i < 4; i++) begin
      s_meta_val[i] = 1'b0; s_info[i] = '0; s_hdr[i] = '0; s_data_val[i] = 1'b0;
      s_data[i] = '0; s_last[i] = 1'b0; s_pad[i] = '0; exp_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_meta_val", merge_udp_meta_val, 1'b0);
    chk("rst_meta_info", merge_udp_meta_info, '0);
    chk("rst_data_val", merge_udp_data_val, 1'b0);
    chk("rst_data", merge_udp_data, '0);
    chk("rst_last_pad", {merge_udp_data_last, merge_udp_data_padbytes}, '0);
    chk("rst_src_rdy", {s_meta_rdy[0], s_meta_rdy[1], s_meta_rdy[2], s_meta_rdy[3],
                        s_data_rdy[0], s_data_rdy[1], s_data_rdy[2], s_data_rdy[3]}, 8'h00);
    chk("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;

    // single short prep message, one output beat
    set_msg(0, 20); push_exp(0, 20); drive_src(0, 20); wait_empty();
    // full-beat commit message, needs a drain beat
    set_msg(1, 64); push_exp(1, 64); drive_src(1, 64); wait_empty();

    // all four at once from reset: prep, commit, vc, setup, then prep again
    do_reset();
    set_msg(0, 30); set_msg(1, 100); set_msg(2, 60); set_msg(3, 128);
    push_exp(0, 30); push_exp(1, 100); push_exp(2, 60); push_exp(3, 128);
    fork
      begin
        drive_src(0, 30);
        set_msg(0, 52); push_exp(0, 52); drive_src(0, 52);
      end
      drive_src(1, 100);
      drive_src(2, 60);
      drive_src(3, 128);
    join
    wait_empty();

    // backpressure on meta then toggling data ready
    meta_stall_cfg = 5;
    data_toggle = 1'b1;
    set_msg(1, 150); push_exp(1, 150); drive_src(1, 150); wait_empty();
    data_toggle = 1'b0;

    // reset in the middle of a three-beat vc message
    set_msg(2, 170); push_exp(2, 170);
    base = beats_seen;
    fork
      drive_src(2, 170);
      begin
        n = 0;
        while (beats_seen < base + 1 && n < BUDGET) begin @(negedge clk); n++; end
        chk("vc_first_beat", beats_seen, base + 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_meta_val", merge_udp_meta_val, 1'b0);
        chk("abort_data_val", merge_udp_data_val, 1'b0);
        chk("abort_data", merge_udp_data, '0);
        chk("abort_last_pad", {merge_udp_data_last, merge_udp_data_padbytes}, '0);
        chk("abort_src_rdy", {s_meta_rdy[0], s_meta_rdy[1], s_meta_rdy[2], s_meta_rdy[3],
                              s_data_rdy[0], s_data_rdy[1], s_data_rdy[2], s_data_rdy[3]}, 8'h00);
        chk("abort_state", state_dbg, ST_IDLE);
        exp_q.delete();
        exp_meta_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    // prep must win over setup after reset
    set_msg(3, 40); set_msg(0, 40);
    push_exp(0, 40); push_exp(3, 40);
    fork
      drive_src(0, 40);
      drive_src(3, 40);
    join
    wait_empty();

    // three setup plus two prep messages from a fresh reset
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_msg(3, 10 + 40 * k); push_exp(3, 10 + 40 * k); drive_src(3, 10 + 40 * k); wait_empty();
    end
    for (int k = 0; k < 2; k++) begin
      set_msg(0, 70 + k); push_exp(0, 70 + k); drive_src(0, 70 + k); wait_empty();
    end
`ifdef VR_TX_MERGE_STATS_EN
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) chk("msg_cnt", tx_msg_cnt[i], exp_cnt[i]);
`endif

    repeat (4) @(negedge clk);
    chk("final_beats_left", exp_q.size(), 0);
    chk("final_meta_left", exp_meta_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
